// File: rtl/zuss_control.sv
// -----------------------------------------------------------------------------
// zuss_control
//
// Multi-cycle control unit for the ZUSS datapath. Each instruction is fetched
// from instruction memory over a req/valid handshake, decoded, and executed.
// The unit drives the datapath register addresses, ALU op and write enable. It
// uses the datapath zero flag to resolve BEQZ, and it owns the program counter
// and the halt condition.
//
// Instruction word:
//   [31:27] opc   [26:22] rd   [21:17] rs1   [16:12] rs2   [11:0] imm12 (signed)
//
// State sequence:
//   ALU  : FETCH -> DECODE -> EXEC -> WB -> FETCH   (4 cycles with no fetch stall)
//   BEQZ : FETCH -> DECODE -> EXEC -> FETCH         (3 cycles with no fetch stall)
//   HALT : FETCH -> DECODE -> EXEC -> HALT (absorbing; leaves only on reset)
//
// Parameters:
//   PC_W     program counter / imem address width (1..32)
//   RESET_PC pc value loaded on reset
//   OP_BEQZ  opcode of the conditional branch
//   OP_HALT  opcode that stops fetching
//   OP_SUB   ALU op driven during a branch, so zr reflects rs1 == rs2
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   imem_addr   out  [PC_W-1:0] fetch address (always equals pc)
//   imem_req    out  fetch request, high in FETCH only (forced low in reset)
//   imem_valid  in   imem_data valid; looked at only in FETCH
//   imem_data   in   [31:0] instruction word
//   zr          in   datapath zero flag, sampled at the end of EXEC
//   r_addr1     out  [4:0] datapath read address 1 (rs1)
//   r_addr2     out  [4:0] datapath read address 2 (rs2)
//   w_addr      out  [4:0] datapath write address (rd)
//   op          out  [4:0] datapath ALU op
//   we          out  datapath register write enable (one cycle, in WB)
//   halted      out  high once HALT has executed
//   retired     out  [15:0] count of retired instructions (optional)
//
// Build option:
//   ZUSS_RETIRE_CNT_EN  when defined, adds the 'retired' output. The counter
//                       increments on every WB cycle and on every EXEC cycle
//                       that executes BEQZ, and it wraps at 16'hFFFF. HALT is
//                       not counted. When the macro is undefined, the port and
//                       the counter are absent.
// -----------------------------------------------------------------------------
module zuss_control #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      OP_BEQZ  = 5'b11110,
    parameter logic [4:0]      OP_HALT  = 5'b11111,
    parameter logic [4:0]      OP_SUB   = 5'b00001
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    input  logic            zr,
    output logic [4:0]      r_addr1,
    output logic [4:0]      r_addr2,
    output logic [4:0]      w_addr,
    output logic [4:0]      op,
    output logic            we,
    output logic            halted
`ifdef ZUSS_RETIRE_CNT_EN
    ,
    output logic [15:0]     retired
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PC_W-1:0] pc;
    logic [31:0]     ir;

    // Instruction fields, taken from the latched instruction register.
    logic [4:0]      ir_opc;
    logic [4:0]      ir_rd;
    logic [4:0]      ir_rs1;
    logic [4:0]      ir_rs2;
    logic [11:0]     ir_imm;

    logic            is_beqz;
    logic            is_halt;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_branch;

    assign ir_opc = ir[31:27];
    assign ir_rd  = ir[26:22];
    assign ir_rs1 = ir[21:17];
    assign ir_rs2 = ir[16:12];
    assign ir_imm = ir[11:0];

    assign is_beqz = (ir_opc == OP_BEQZ);
    assign is_halt = (ir_opc == OP_HALT);

    // Both next-pc candidates wrap modulo 2^PC_W. The signed cast
    // sign-extends imm12 when PC_W is wider than 12 bits and truncates it
    // when PC_W is narrower. A negative offset below address 0 therefore
    // wraps to the top of the address space.
    assign pc_inc    = pc + PC_W'(1);
    assign pc_branch = pc + PC_W'($signed(ir_imm));

    assign imem_addr = pc;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    // we and imem_req are decoded from the state register only, so they cannot
    // glitch. imem_req is also gated by rst_n. The reset state is FETCH, but
    // no request may be issued while reset is held.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        we         = 1'b0;

        unique case (state)
            FETCH: begin
                imem_req = rst_n;
                if (imem_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                if (is_halt) begin
                    state_next = HALT;
                end else if (is_beqz) begin
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            WB: begin
                we         = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Instruction register: loaded only when FETCH sees a valid response.
    // A response that arrives in any other state is ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (state == FETCH && imem_valid) begin
            ir <= imem_data;
        end
    end

    // -------------------------------------------------------------------------
    // Program counter
    // -------------------------------------------------------------------------
    // pc advances in exactly two places: at the end of WB, and at the end of
    // an EXEC cycle that executes BEQZ. HALT leaves pc pointing at the HALT
    // instruction itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            unique case (state)
                EXEC: begin
                    if (is_beqz) begin
                        pc <= zr ? pc_branch : pc_inc;
                    end
                end
                WB: begin
                    pc <= pc_inc;
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath address and op registers
    // -------------------------------------------------------------------------
    // These registers load only on the DECODE -> EXEC edge. They then hold
    // steady through EXEC and WB, so the datapath sees the same operands in
    // the cycle that produces zr and in the cycle that writes back. BEQZ
    // drives SUB, so zr reports rs1 == rs2. rd is passed through unchanged,
    // even when it is 0, because r0 handling belongs to the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr1 <= '0;
            r_addr2 <= '0;
            w_addr  <= '0;
            op      <= '0;
        end else if (state == DECODE) begin
            r_addr1 <= ir_rs1;
            r_addr2 <= ir_rs2;
            w_addr  <= ir_rd;
            op      <= is_beqz ? OP_SUB : ir_opc;
        end
    end

    // -------------------------------------------------------------------------
    // Halt flag: set as EXEC resolves a HALT. It clears only on reset, which
    // is also the only way out of the HALT state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (state == EXEC && is_halt) begin
            halted <= 1'b1;
        end
    end

`ifdef ZUSS_RETIRE_CNT_EN
    // -------------------------------------------------------------------------
    // Retired-instruction counter. An ALU instruction retires in WB. A BEQZ
    // retires in its EXEC cycle. HALT never retires. The counter wraps
    // naturally at 16 bits.
    // -------------------------------------------------------------------------
    logic retire_pulse;

    assign retire_pulse = (state == WB) || (state == EXEC && is_beqz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire_pulse) begin
            retired <= retired + 16'd1;
        end
    end
`else
    // Retire counting is compiled out; no port and no counter exist.
`endif

endmodule

// File: tb/tb_zuss_control.sv
// -----------------------------------------------------------------------------
// tb_zuss_control
//
// Directed bench for zuss_control (PC_W = 8, RESET_PC = 0). Inputs are driven
// and outputs are sampled on the falling clock edge, so the DUT sees stable
// inputs at every rising edge. Expected values are hand-computed constants,
// plus a small model of the last decoded fields and of the current pc.
// -----------------------------------------------------------------------------
module tb_zuss_control;

    localparam logic [4:0] OP_BEQZ = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [4:0] OP_SUB  = 5'b00001;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        zr;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic [4:0]  w_addr;
    logic [4:0]  op;
    logic        we;
    logic        halted;
`ifdef ZUSS_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model of what the DUT should currently present.
    logic [7:0] pc_model;
    logic [4:0] exp_ra1, exp_ra2, exp_wa, exp_op;

    zuss_control #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .zr         (zr),
        .r_addr1    (r_addr1),
        .r_addr2    (r_addr2),
        .w_addr     (w_addr),
        .op         (op),
        .we         (we),
        .halted     (halted)
`ifdef ZUSS_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pc_model = 8'h00;
        exp_ra1  = '0;
        exp_ra2  = '0;
        exp_wa   = '0;
        exp_op   = '0;
    endtask

    task automatic check_dp(input string tag);
        check({tag, "_ra1"}, r_addr1, exp_ra1);
        check({tag, "_ra2"}, r_addr2, exp_ra2);
        check({tag, "_wa"},  w_addr,  exp_wa);
        check({tag, "_op"},  op,      exp_op);
    endtask

    // Entered at a falling edge in FETCH. Stalls the response for 'stall'
    // cycles and returns at the falling edge of DECODE.
    task automatic deliver(input logic [31:0] instr, input int stall);
        check("fetch_req",  imem_req,  1'b1);
        check("fetch_addr", imem_addr, pc_model);
        check("fetch_we",   we,        1'b0);
        for (int i = 0; i < stall; i++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            check("stall_req",  imem_req,  1'b1);
            check("stall_addr", imem_addr, pc_model);
            check("stall_we",   we,        1'b0);
            check_dp("stall");
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        check("decode_req", imem_req, 1'b0);
        check("decode_we",  we,       1'b0);
        check_dp("decode");
    endtask

    task automatic run_alu(input logic [4:0] opc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input int stall);
        int start;
        start = cyc;
        deliver({opc, rd, rs1, rs2, 12'h000}, stall);
        exp_ra1 = rs1; exp_ra2 = rs2; exp_wa = rd; exp_op = opc;
        @(negedge clk);
        check("exec_we", we, 1'b0);
        check_dp("exec");
        @(negedge clk);
        check("wb_we", we, 1'b1);
        check_dp("wb");
        @(negedge clk);
        pc_model = pc_model + 8'd1;
        check("alu_next_addr", imem_addr, pc_model);
        check("alu_next_we",   we,        1'b0);
        check("alu_latency",   cyc - start, 4 + stall);
    endtask

    task automatic run_beqz(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                            input logic zr_val, input int stall, input logic [7:0] exp_next);
        int start;
        start = cyc;
        zr = ~zr_val;
        deliver({OP_BEQZ, 5'd10, rs1, rs2, imm}, stall);
        exp_ra1 = rs1; exp_ra2 = rs2; exp_wa = 5'd10; exp_op = OP_SUB;
        @(negedge clk);
        zr = zr_val;
        check("beqz_exec_we", we, 1'b0);
        check_dp("beqz_exec");
        @(negedge clk);
        zr = 1'b0;
        check("beqz_next_addr", imem_addr, exp_next);
        check("beqz_next_we",   we,        1'b0);
        check("beqz_next_req",  imem_req,  1'b1);
        check("beqz_latency",   cyc - start, 3 + stall);
        pc_model = exp_next;
    endtask

    // Asserts reset at the current time, checks the reset values, and
    // releases reset at the next falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req",    imem_req,  1'b0);
        check("rst_we",     we,        1'b0);
        check("rst_halted", halted,    1'b0);
        check("rst_addr",   imem_addr, 8'h00);
        model_clear();
        check_dp("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req",  imem_req,  1'b1);
        check("rel_addr", imem_addr, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        imem_valid = 1'b0;
        imem_data  = '0;
        zr         = 1'b0;
        model_clear();
        #1;
        @(negedge clk);
        pulse_reset();

        // ALU op 0 writing rd=0: rs1=1, rs2=2 at pc 0 -> pc 1.
        run_alu(5'h00, 5'd0, 5'd1, 5'd2, 0);
        // Three-cycle fetch stall at pc 1 -> pc 2; latency becomes 7.
        run_alu(5'h03, 5'd9, 5'd4, 5'd6, 3);

        // Branches: 2 + 3 = 5, 5 - 3 = 2, 2 + 3 = 5 (with a stall),
        // 5 not taken = 6, 6 - 7 wraps to 8'hFF.
        run_beqz(5'd1, 5'd1, 12'h003, 1'b1, 0, 8'h05);
        run_beqz(5'd2, 5'd2, 12'hFFD, 1'b1, 0, 8'h02);
        run_beqz(5'd3, 5'd4, 12'h003, 1'b1, 1, 8'h05);
        run_beqz(5'd3, 5'd4, 12'hFFD, 1'b0, 0, 8'h06);
        run_beqz(5'd5, 5'd5, 12'hFF9, 1'b1, 0, 8'hFF);

        // ALU op at 8'hFF wraps to 8'h00.
        run_alu(5'h02, 5'd31, 5'd30, 5'd29, 0);
        check("wrap_addr", imem_addr, 8'h00);

        // HALT at pc 0. A valid response offered during HALT must be ignored.
        deliver({OP_HALT, 5'd0, 5'd0, 5'd0, 12'h000}, 0);
        exp_ra1 = 5'd0; exp_ra2 = 5'd0; exp_wa = 5'd0; exp_op = OP_HALT;
        @(negedge clk);
        check("halt_exec_halted", halted, 1'b0);
        check_dp("halt_exec");
        imem_valid = 1'b1;
        imem_data  = {5'h01, 5'd1, 5'd1, 5'd1, 12'h000};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_halted", halted,    1'b1);
            check("halt_req",    imem_req,  1'b0);
            check("halt_we",     we,        1'b0);
            check("halt_addr",   imem_addr, 8'h00);
        end
        imem_valid = 1'b0;
        pulse_reset();
        check("post_halt_halted", halted, 1'b0);

        // Asynchronous reset in the middle of WB, at pc 1.
        run_alu(5'h04, 5'd1, 5'd2, 5'd3, 0);
        deliver({5'h05, 5'd7, 5'd8, 5'd9, 12'h000}, 0);
        @(negedge clk);
        @(negedge clk);
        check("midwb_we_before", we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwb_we_async",  we,       1'b0);
        check("midwb_req_async", imem_req, 1'b0);
        check("midwb_wa_async",  w_addr,   5'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midwb_rel_addr", imem_addr, 8'h00);
        check("midwb_rel_req",  imem_req,  1'b1);
        @(negedge clk);

`ifdef ZUSS_RETIRE_CNT_EN
        check("retired_reset", retired, 16'd0);
`endif
        run_alu(5'h06, 5'd11, 5'd12, 5'd13, 0);
        run_alu(5'h07, 5'd14, 5'd15, 5'd16, 0);
        run_beqz(5'd17, 5'd17, 12'h005, 1'b1, 0, 8'h07);
`ifdef ZUSS_RETIRE_CNT_EN
        check("retired_three", retired, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
